lc3_ea_unit: RTL and testbench

- Parametrised, handshaked effective-address generator for the LC-3 datapath; successor to the combinational ADDR1MUX/ADDR2MUX/adder path.
- Computes base (PC or SR1) + sign-extended IR offset (0, 6-, 9- or 11-bit field by default), registers the result and presents it over a valid/ready interface.
- Adds an indirect mode (LDI/STI): issues one memory read at the computed address and returns the fetched word as the final EA.
- Has a bounded memory wait: a timeout flags an error.

---
 rtl/lc3_ea_unit.sv | 122 ++++++++++++
 tb/tb_lc3_ea_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_ea_unit.sv
// LC-3 effective-address generator: base + sext(IR offset), optional
// indirect fetch through memory with a bounded wait, valid/ready output.
module lc3_ea_unit #(
   parameter int W       = 16,
   parameter int OFF_A   = 6,
   parameter int OFF_B   = 9,
   parameter int OFF_C   = 11,
   parameter int TIMEOUT = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_PC,
   input  logic [W-1:0] i_SR1,
   input  logic [W-1:0] i_IR,
   input  logic         i_addr1mux,
   input  logic [1:0]   i_addr2mux,
   input  logic         i_indirect,
   output logic         o_mem_req,
   output logic [W-1:0] o_mem_addr,
   input  logic         i_mem_ack,
   input  logic [W-1:0] i_mem_rdata,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_ea,
   output logic         o_err
);

   generate
      if (OFF_A >= W || OFF_B >= W || OFF_C >= W) begin : g_bad_field
         $error("lc3_ea_unit: offset field must be narrower than W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, MEM, OUT} state_t;

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam bit TO_EN = (TIMEOUT > 0);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state, state_n;
   logic [W-1:0]  ea_r, ea_n;
   logic          err_r, err_n;
   logic [CW-1:0] cnt, cnt_n;

   logic [W-1:0] sext_a, sext_b, sext_c;
   logic [W-1:0] base, off, sum;

   assign sext_a = {{(W-OFF_A){i_IR[OFF_A-1]}}, i_IR[OFF_A-1:0]};
   assign sext_b = {{(W-OFF_B){i_IR[OFF_B-1]}}, i_IR[OFF_B-1:0]};
   assign sext_c = {{(W-OFF_C){i_IR[OFF_C-1]}}, i_IR[OFF_C-1:0]};

   always_comb begin
      base = i_addr1mux ? i_SR1 : i_PC;
      off  = '0;
      unique case (i_addr2mux)
         2'b00: off = '0;
         2'b01: off = sext_a;
         2'b10: off = sext_b;
         2'b11: off = sext_c;
         default: off = '0;
      endcase
      sum = base + off;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         ea_r  <= '0;
         err_r <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         ea_r  <= ea_n;
         err_r <= err_n;
         cnt   <= cnt_n;
      end
   end

   // An ack in the last wait cycle takes priority over the timeout.
   always_comb begin
      state_n = state;
      ea_n    = ea_r;
      err_n   = err_r;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (i_valid) begin
               ea_n    = sum;
               err_n   = 1'b0;
               state_n = i_indirect ? MEM : OUT;
            end
         end
         MEM: begin
            if (i_mem_ack) begin
               ea_n    = i_mem_rdata;
               cnt_n   = '0;
               state_n = OUT;
            end else if (TO_EN && cnt == CNT_LAST) begin
               err_n   = 1'b1;
               cnt_n   = '0;
               state_n = OUT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         OUT: begin
            if (i_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign o_ready    = (state == IDLE);
   assign o_mem_req  = (state == MEM);
   assign o_valid    = (state == OUT);
   assign o_mem_addr = ea_r;
   assign o_ea       = ea_r;
   assign o_err      = err_r;

endmodule

// File: tb/tb_lc3_ea_unit.sv
// Directed self-checking bench for lc3_ea_unit: direct sums, wrap,
// indirect fetch, timeout, output hold, and asynchronous reset.
module tb_lc3_ea_unit;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_PC, i_SR1, i_IR;
   logic        i_addr1mux;
   logic [1:0]  i_addr2mux;
   logic        i_indirect;
   logic        o_mem_req;
   logic [15:0] o_mem_addr;
   logic        i_mem_ack;
   logic [15:0] i_mem_rdata;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_ea;
   logic        o_err;

   int n_chk  = 0;
   int n_pass = 0;
   int nreq;

   lc3_ea_unit #(
      .W(16), .OFF_A(6), .OFF_B(9), .OFF_C(11), .TIMEOUT(8)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_PC(i_PC), .i_SR1(i_SR1), .i_IR(i_IR),
      .i_addr1mux(i_addr1mux), .i_addr2mux(i_addr2mux),
      .i_indirect(i_indirect),
      .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_ea(o_ea), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Present a request for one cycle; returns at the negedge after accept.
   task automatic req(input logic [15:0] pc, input logic [15:0] sr1,
                      input logic [15:0] ir, input logic a1,
                      input logic [1:0] a2, input logic ind);
      i_PC = pc; i_SR1 = sr1; i_IR = ir;
      i_addr1mux = a1; i_addr2mux = a2; i_indirect = ind;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_PC = 16'hDEAD; i_SR1 = 16'hBEEF; i_IR = 16'h0000;
   endtask

   task automatic pop();
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
   endtask

   task automatic direct(input string tag, input logic [15:0] pc,
                         input logic [15:0] sr1, input logic [15:0] ir,
                         input logic a1, input logic [1:0] a2,
                         input logic [15:0] exp);
      req(pc, sr1, ir, a1, a2, 1'b0);
      chk({tag, "_valid"}, 16'(o_valid), 16'd1);
      chk({tag, "_ea"}, o_ea, exp);
      chk({tag, "_err"}, 16'(o_err), 16'd0);
      pop();
      chk({tag, "_ready"}, 16'(o_ready), 16'd1);
   endtask

   // Walk MEM cycles; ack_cyc = 0 means never acknowledge.
   task automatic run_mem(input int ack_cyc, input logic [15:0] rdata);
      nreq = 0;
      for (int c = 1; c <= 20 && !o_valid; c++) begin
         if (o_mem_req) nreq++;
         i_mem_ack   = (c == ack_cyc);
         i_mem_rdata = rdata;
         @(negedge i_clk);
      end
      i_mem_ack = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
      i_PC = '0; i_SR1 = '0; i_IR = '0;
      i_addr1mux = 1'b0; i_addr2mux = 2'b00; i_indirect = 1'b0;
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      #1;
      chk("rst_ready", 16'(o_ready), 16'd1);
      chk("rst_valid", 16'(o_valid), 16'd0);
      chk("rst_req", 16'(o_mem_req), 16'd0);
      chk("rst_addr", o_mem_addr, 16'h0000);
      chk("rst_ea", o_ea, 16'h0000);
      chk("rst_err", 16'(o_err), 16'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);

      direct("pc_b", 16'h3000, 16'h0000, 16'h01FF, 1'b0, 2'b10, 16'h2FFF);
      direct("sr_a", 16'h0000, 16'h4000, 16'h0020, 1'b1, 2'b01, 16'h3FE0);
      direct("wrap", 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 2'b01, 16'h0000);
      direct("zero", 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 2'b00, 16'h1234);
      direct("pc_c", 16'h0000, 16'h0000, 16'h0400, 1'b0, 2'b11, 16'hFC00);
      direct("pos_b", 16'h3000, 16'h0000, 16'hFE05, 1'b0, 2'b10, 16'h3005);

      // Ack outside MEM must be ignored.
      i_mem_ack = 1'b1; i_mem_rdata = 16'h7777;
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      chk("idle_ack_valid", 16'(o_valid), 16'd0);
      chk("idle_ack_ready", 16'(o_ready), 16'd1);

      req(16'h3000, 16'h0000, 16'h0005, 1'b0, 2'b10, 1'b1);
      chk("ind3_req", 16'(o_mem_req), 16'd1);
      chk("ind3_addr", o_mem_addr, 16'h3005);
      chk("ind3_ready", 16'(o_ready), 16'd0);
      run_mem(3, 16'h4100);
      chk("ind3_nreq", 16'(nreq), 16'd3);
      chk("ind3_valid", 16'(o_valid), 16'd1);
      chk("ind3_ea", o_ea, 16'h4100);
      chk("ind3_err", 16'(o_err), 16'd0);
      chk("ind3_req_off", 16'(o_mem_req), 16'd0);
      pop();

      req(16'h3000, 16'h0000, 16'h0005, 1'b0, 2'b10, 1'b1);
      run_mem(1, 16'h5150);
      chk("ind1_nreq", 16'(nreq), 16'd1);
      chk("ind1_valid", 16'(o_valid), 16'd1);
      chk("ind1_ea", o_ea, 16'h5150);
      chk("ind1_err", 16'(o_err), 16'd0);
      pop();

      req(16'h3000, 16'h0000, 16'h0005, 1'b0, 2'b10, 1'b1);
      run_mem(0, 16'h9999);
      chk("to_nreq", 16'(nreq), 16'd8);
      chk("to_valid", 16'(o_valid), 16'd1);
      chk("to_err", 16'(o_err), 16'd1);
      chk("to_ea", o_ea, 16'h3005);
      pop();

      req(16'h3000, 16'h0000, 16'h0005, 1'b0, 2'b10, 1'b1);
      run_mem(8, 16'hABCD);
      chk("ack8_nreq", 16'(nreq), 16'd8);
      chk("ack8_valid", 16'(o_valid), 16'd1);
      chk("ack8_err", 16'(o_err), 16'd0);
      chk("ack8_ea", o_ea, 16'hABCD);
      pop();

      // Back-pressure: outputs frozen, new requests ignored.
      req(16'h3000, 16'h0000, 16'h01FF, 1'b0, 2'b10, 1'b0);
      for (int i = 0; i < 5; i++) begin
         i_valid = i[0] ? 1'b0 : 1'b1;
         i_PC = 16'h1000 + 16'(i); i_addr2mux = 2'b00;
         i_indirect = i[1];
         @(negedge i_clk);
         chk("hold_valid", 16'(o_valid), 16'd1);
         chk("hold_ea", o_ea, 16'h2FFF);
         chk("hold_err", 16'(o_err), 16'd0);
         chk("hold_ready", 16'(o_ready), 16'd0);
      end
      i_valid = 1'b0;
      pop();
      chk("rel_ready", 16'(o_ready), 16'd1);
      chk("rel_valid", 16'(o_valid), 16'd0);
      chk("rel_req", 16'(o_mem_req), 16'd0);

      // Asynchronous reset in the middle of a memory wait.
      req(16'h3000, 16'h0000, 16'h0005, 1'b0, 2'b10, 1'b1);
      @(negedge i_clk);
      @(negedge i_clk);
      chk("pre_rst_req", 16'(o_mem_req), 16'd1);
      #2 i_rst = 1'b1;
      #1;
      chk("arst_req", 16'(o_mem_req), 16'd0);
      chk("arst_valid", 16'(o_valid), 16'd0);
      chk("arst_ea", o_ea, 16'h0000);
      chk("arst_ready", 16'(o_ready), 16'd1);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      direct("post_rst", 16'h0100, 16'h0000, 16'h001F, 1'b0, 2'b01,
             16'h011F);
      req(16'h3000, 16'h0000, 16'h0005, 1'b0, 2'b10, 1'b1);
      run_mem(0, 16'h0000);
      chk("post_rst_nreq", 16'(nreq), 16'd8);
      chk("post_rst_err", 16'(o_err), 16'd1);
      pop();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
